// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the fetch (IF) and execute (EX) requesters.
// Optional access timeout: define MEM_TIMEOUT_EN.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX  = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ex_req,
    input  logic        ex_we,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [3:0]  ex_be,
    output logic        ex_gnt,
    output logic        ex_rvalid,
    output logic [31:0] ex_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_EX = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_r, state_s;
    logic [3:0]  starve_r;
    logic        if_gnt_s, ex_gnt_s, done_s, abort_s, timeout_s;
    logic        mem_req_r, mem_we_r;
    logic [31:0] mem_addr_r, mem_wdata_r;
    logic [3:0]  mem_be_r;
    logic        if_rvalid_r, ex_rvalid_r, err_r;
    logic [31:0] if_rdata_r, ex_rdata_r;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] tcnt_r;

    assign timeout_s = (tcnt_r == TW'(TIMEOUT_CYC - 1));

    // Busy cycles elapsed since the grant; abort fires on the TIMEOUT_CYC-th one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_r <= {TW{1'b0}};
        end else if (if_gnt_s || ex_gnt_s) begin
            tcnt_r <= {TW{1'b0}};
        end else if (state_r != IDLE) begin
            tcnt_r <= tcnt_r + TW'(1);
        end else begin
            tcnt_r <= tcnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Grant decision and next-state logic.
    always_comb begin
        state_s  = state_r;
        if_gnt_s = 1'b0;
        ex_gnt_s = 1'b0;
        done_s   = 1'b0;
        abort_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (ex_req && !(if_req && (starve_r == STARVE_LIM))) begin
                    ex_gnt_s = 1'b1;
                    state_s  = BUSY_EX;
                end else if (if_req) begin
                    if_gnt_s = 1'b1;
                    state_s  = BUSY_IF;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY_IF, BUSY_EX: begin
                if (mem_ready) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else if (timeout_s) begin
                    abort_s = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            starve_r <= 4'd0;
        end else begin
            state_r <= state_s;
            if (if_gnt_s) begin
                starve_r <= 4'd0;
            end else if (ex_gnt_s && if_req && (starve_r != STARVE_LIM)) begin
                starve_r <= starve_r + 4'd1;
            end else begin
                starve_r <= starve_r;
            end
        end
    end

    // Memory-side request registers, loaded at grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            mem_be_r    <= 4'd0;
        end else if (if_gnt_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= if_addr;
            mem_wdata_r <= 32'd0;
            mem_be_r    <= 4'b1111;
        end else if (ex_gnt_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= ex_we;
            mem_addr_r  <= ex_addr;
            mem_wdata_r <= ex_wdata;
            mem_be_r    <= ex_be;
        end else if (done_s || abort_s) begin
            mem_req_r <= 1'b0;
        end else begin
            mem_req_r <= mem_req_r;
        end
    end

    // Completion pulses and per-side read data; aborted accesses and stores return zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rvalid_r <= 1'b0;
            ex_rvalid_r <= 1'b0;
            err_r       <= 1'b0;
            if_rdata_r  <= 32'd0;
            ex_rdata_r  <= 32'd0;
        end else begin
            if_rvalid_r <= 1'b0;
            ex_rvalid_r <= 1'b0;
            err_r       <= 1'b0;
            if ((done_s || abort_s) && (state_r == BUSY_IF)) begin
                if_rvalid_r <= 1'b1;
                err_r       <= abort_s;
                if_rdata_r  <= abort_s ? 32'd0 : mem_rdata;
            end else if ((done_s || abort_s) && (state_r == BUSY_EX)) begin
                ex_rvalid_r <= 1'b1;
                err_r       <= abort_s;
                ex_rdata_r  <= (abort_s || mem_we_r) ? 32'd0 : mem_rdata;
            end else begin
                if_rdata_r <= if_rdata_r;
                ex_rdata_r <= ex_rdata_r;
            end
        end
    end

    assign if_gnt    = if_gnt_s & ~rst;
    assign ex_gnt    = ex_gnt_s & ~rst;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_be    = mem_be_r;
    assign if_rvalid = if_rvalid_r;
    assign ex_rvalid = ex_rvalid_r;
    assign if_rdata  = if_rdata_r;
    assign ex_rdata  = ex_rdata_r;
    assign err       = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level model.
// Build with MEM_TIMEOUT_EN defined to exercise the timeout path.
module tb_mem_arbiter;

    localparam int TB_STARVE = 4;
    localparam int TB_TO     = 8;
`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        if_req = 1'b0, ex_req = 1'b0, ex_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] if_addr = 32'd0, ex_addr = 32'd0, ex_wdata = 32'd0, mem_rdata = 32'd0;
    logic [3:0]  ex_be = 4'd0;
    logic        if_gnt, if_rvalid, ex_gnt, ex_rvalid, mem_req, mem_we, err;
    logic [31:0] if_rdata, ex_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.STARVE_MAX(TB_STARVE), .TIMEOUT_CYC(TB_TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_be(ex_be),
        .ex_gnt(ex_gnt), .ex_rvalid(ex_rvalid), .ex_rdata(ex_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Transaction-level reference: one access in flight, owner, elapsed wait, response pulses.
    bit          m_busy, m_owner_ex, m_we, m_rv_if, m_rv_ex, m_err;
    bit          m_if_gnt, m_ex_gnt;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_ex_rdata;
    logic [3:0]  m_be;
    int          m_wait, m_streak;

    always @(negedge clk) begin
        bit g_if, g_ex;
        if (rst) begin
            chk("rst_if_gnt", 32'(if_gnt), 32'd0);
            chk("rst_ex_gnt", 32'(ex_gnt), 32'd0);
            chk("rst_rvalid", {30'd0, if_rvalid, ex_rvalid}, 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_mem_fields", mem_addr | mem_wdata | 32'(mem_be) | 32'(mem_we), 32'd0);
            chk("rst_rdata", if_rdata | ex_rdata, 32'd0);
            m_busy = 0; m_rv_if = 0; m_rv_ex = 0; m_err = 0; m_if_gnt = 0; m_ex_gnt = 0;
            m_if_rdata = 32'd0; m_ex_rdata = 32'd0; m_streak = 0; m_wait = 0;
        end else begin
            g_if = 0; g_ex = 0;
            if (!m_busy) begin
                if (ex_req && if_req) begin
                    if (m_streak == TB_STARVE) g_if = 1; else g_ex = 1;
                end else if (ex_req) g_ex = 1;
                else if (if_req) g_if = 1;
            end
            chk("if_gnt", 32'(if_gnt), 32'(g_if));
            chk("ex_gnt", 32'(ex_gnt), 32'(g_ex));
            chk("mem_req", 32'(mem_req), 32'(m_busy));
            if (m_busy) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_we", 32'(mem_we), 32'(m_we));
                chk("mem_be", 32'(mem_be), 32'(m_be));
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
            chk("if_rvalid", 32'(if_rvalid), 32'(m_rv_if));
            chk("ex_rvalid", 32'(ex_rvalid), 32'(m_rv_ex));
            chk("err", 32'(err), 32'(m_err));
            chk("if_rdata", if_rdata, m_if_rdata);
            chk("ex_rdata", ex_rdata, m_ex_rdata);

            m_rv_if = 0; m_rv_ex = 0; m_err = 0;
            if (m_busy) begin
                m_wait++;
                if (mem_ready || (TO_EN && m_wait == TB_TO)) begin
                    m_busy = 0;
                    m_err  = !mem_ready;
                    if (m_owner_ex) begin
                        m_rv_ex = 1;
                        m_ex_rdata = (m_we || !mem_ready) ? 32'd0 : mem_rdata;
                    end else begin
                        m_rv_if = 1;
                        m_if_rdata = mem_ready ? mem_rdata : 32'd0;
                    end
                end
            end else if (g_if) begin
                m_busy = 1; m_owner_ex = 0; m_wait = 0; m_streak = 0;
                m_addr = if_addr; m_we = 0; m_be = 4'b1111;
            end else if (g_ex) begin
                m_busy = 1; m_owner_ex = 1; m_wait = 0;
                if (if_req && m_streak < TB_STARVE) m_streak++;
                m_addr = ex_addr; m_we = ex_we; m_be = ex_be; m_wdata = ex_wdata;
            end
            m_if_gnt = g_if;
            m_ex_gnt = g_ex;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            if_req = 1'b0; ex_req = 1'b0; mem_ready = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord[$];
        int exp_ord[12] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2, 1, 1};
        int req_cnt, stall;

        // reset state
        tick();
        #2;
        chk("lit_reset_mem_req", 32'(mem_req), 32'd0);
        tick();
        rst = 1'b0;

        // single load
        tick();
        ex_req = 1; ex_we = 0; ex_addr = 32'h100; ex_be = 4'hF; mem_ready = 0;
        #2 chk("lit_load_gnt", 32'(ex_gnt), 32'd1);
        tick();
        ex_req = 0;
        #2 chk("lit_load_addr", mem_addr, 32'h100);
        tick();
        tick();
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ready = 0;
        #2;
        chk("lit_load_rvalid", 32'(ex_rvalid), 32'd1);
        chk("lit_load_rdata", ex_rdata, 32'hDEADBEEF);
        chk("lit_load_no_if_gnt", 32'(if_gnt), 32'd0);

        // store
        tick();
        ex_req = 1; ex_we = 1; ex_addr = 32'h20; ex_wdata = 32'hAB; ex_be = 4'b0001;
        tick();
        ex_req = 0; mem_ready = 0;
        #2;
        chk("lit_store_we", 32'(mem_we), 32'd1);
        chk("lit_store_be", 32'(mem_be), 32'd1);
        chk("lit_store_wdata", mem_wdata, 32'hAB);
        tick();
        mem_ready = 1; mem_rdata = 32'hFFFFFFFF;
        tick();
        mem_ready = 0;
        #2;
        chk("lit_store_rvalid", 32'(ex_rvalid), 32'd1);
        chk("lit_store_rdata", ex_rdata, 32'd0);
        idle(2);

        // contention: both held, memory always ready
        ex_we = 0; ex_addr = 32'h500; if_addr = 32'h600;
        for (int c = 0; c < 24; c++) begin
            tick();
            if_req = 1; ex_req = 1; mem_ready = 1; mem_rdata = 32'hC0DE0000 + 32'(c);
            #2;
            if (ex_gnt) ord.push_back(1);
            if (if_gnt) ord.push_back(2);
            if (c == 10) begin
                chk("lit_starve_if_rvalid", 32'(if_rvalid), 32'd1);
                chk("lit_starve_if_rdata", if_rdata, 32'hC0DE0009);
            end
        end
        chk("lit_starve_count", 32'(ord.size()), 32'd12);
        for (int i = 0; i < 12 && i < ord.size(); i++)
            chk("lit_starve_order", 32'(ord[i]), 32'(exp_ord[i]));
        idle(3);

`ifndef MEM_TIMEOUT_EN
        // wait states with EX arriving mid-access
        tick();
        if_req = 1; if_addr = 32'h40; mem_ready = 0;
        req_cnt = 0;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if_req = 0;
            if (c == 5) begin ex_req = 1; ex_we = 0; ex_addr = 32'h200; end
            mem_ready = (c == 11); mem_rdata = (c == 11) ? 32'h13 : 32'h0BAD0BAD;
            #2;
            if (mem_req) req_cnt++;
            if (c >= 5) chk("lit_wait_no_ex_gnt", 32'(ex_gnt), 32'd0);
        end
        tick();
        mem_ready = 0;
        #2;
        chk("lit_wait_mem_req_len", 32'(req_cnt), 32'd11);
        chk("lit_wait_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("lit_wait_if_rdata", if_rdata, 32'h13);
        chk("lit_wait_ex_gnt", 32'(ex_gnt), 32'd1);
        tick();
        ex_req = 0;
        idle(3);
`else
        // timeout abort, then a late ready that must be ignored
        tick();
        ex_req = 1; ex_we = 0; ex_addr = 32'h400; mem_ready = 0;
        repeat (TB_TO) begin
            tick();
            ex_req = 0;
        end
        tick();
        #2;
        chk("lit_to_rvalid", 32'(ex_rvalid), 32'd1);
        chk("lit_to_err", 32'(err), 32'd1);
        chk("lit_to_rdata", ex_rdata, 32'd0);
        chk("lit_to_mem_req", 32'(mem_req), 32'd0);
        tick();
        mem_ready = 1; mem_rdata = 32'h55555555;
        tick();
        mem_ready = 0;
        #2;
        chk("lit_to_late_rvalid", {30'd0, ex_rvalid, err}, 32'd0);
        idle(2);
`endif

        // async reset mid-BUSY_EX
        tick();
        ex_req = 1; ex_we = 0; ex_addr = 32'h300; mem_ready = 0;
        tick();
        ex_req = 0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("lit_rst_mem_req", 32'(mem_req), 32'd0);
        chk("lit_rst_ex_gnt", 32'(ex_gnt), 32'd0);
        chk("lit_rst_ex_rvalid", 32'(ex_rvalid), 32'd0);
        tick();
        mem_ready = 1;
        tick();
        rst = 1'b0; if_req = 1; if_addr = 32'h80;
        #1 chk("lit_rst_if_gnt", 32'(if_gnt), 32'd1);
        tick();
        if_req = 0;
        #2 chk("lit_rst_no_ex_rvalid", 32'(ex_rvalid), 32'd0);
        tick();
        #2 chk("lit_rst_no_ex_rvalid2", 32'(ex_rvalid), 32'd0);
        idle(2);

        // randomized traffic with bursty memory stalls
        stall = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!if_req || m_if_gnt) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = $urandom;
            end
            if (!ex_req || m_ex_gnt) begin
                ex_req   = ($urandom_range(0, 2) != 0);
                ex_we    = 1'($urandom);
                ex_addr  = $urandom;
                ex_wdata = $urandom;
                ex_be    = 4'($urandom);
            end
            if (stall == 0) begin
                if ($urandom_range(0, 9) == 0) stall = $urandom_range(5, 12);
                else stall = $urandom_range(0, 2);
            end
            mem_ready = (stall == 0);
            if (stall > 0) stall--;
            mem_rdata = $urandom;
        end
        idle(TB_TO + 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
